// File: rtl/ps2_rx_if.sv
// rtl/ps2_rx_if.sv - PS/2 line inputs and received byte / key event outputs
interface ps2_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       parity_err;
    logic       frame_err;
    logic       timeout_err;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_pressed;
    logic       key_strobe;

    modport master (
        input  ps2_clk, ps2_data,
        output rx_byte, rx_strobe, parity_err, frame_err, timeout_err,
        output key_code, key_ext, key_pressed, key_strobe
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  rx_byte, rx_strobe, parity_err, frame_err, timeout_err,
        input  key_code, key_ext, key_pressed, key_strobe
    );
endinterface

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver with line filtering, watchdog and scan-code assembly
module ps2_rx #(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 20000
) (
    input  logic     clk_sys,
    input  logic     reset,
    ps2_rx_if.master bus
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam logic [3:0]  FILT_LAST = 4'(FILTER - 1);
    localparam logic [15:0] WD_LIMIT  = 16'(TIMEOUT);

    logic [1:0]  clk_sync, data_sync;
    logic        clk_filt, data_filt, clk_filt_d, fall;
    logic [3:0]  clk_cnt, data_cnt;
    state_t      state, state_nxt;
    logic [7:0]  shift;
    logic [2:0]  bit_cnt;
    logic        parity_acc;
    logic [15:0] wd_cnt;
    logic        wd_expired;
    logic        ev_good, ev_parity, ev_frame, ev_timeout;
    logic [7:0]  rx_byte;
    logic        rx_strobe, parity_err, frame_err, timeout_err;
    logic [7:0]  key_code;
    logic        key_ext, key_pressed, key_strobe, ext, rel;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_filt_d <= 1'b1;
            fall       <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], bus.ps2_clk};
            data_sync  <= {data_sync[0], bus.ps2_data};
            clk_filt_d <= clk_filt;
            fall       <= clk_filt_d & ~clk_filt;
        end
    end

    // The filtered level only moves after FILTER consecutive disagreeing samples.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_filt <= 1'b1;
            clk_cnt  <= '0;
        end else if (clk_sync[1] != clk_filt) begin
            if (clk_cnt == FILT_LAST) begin
                clk_filt <= clk_sync[1];
                clk_cnt  <= '0;
            end else begin
                clk_cnt <= clk_cnt + 4'd1;
            end
        end else begin
            clk_cnt <= '0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            data_filt <= 1'b1;
            data_cnt  <= '0;
        end else if (data_sync[1] != data_filt) begin
            if (data_cnt == FILT_LAST) begin
                data_filt <= data_sync[1];
                data_cnt  <= '0;
            end else begin
                data_cnt <= data_cnt + 4'd1;
            end
        end else begin
            data_cnt <= '0;
        end
    end

    assign wd_expired = (wd_cnt == WD_LIMIT);

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A fall in the same cycle as watchdog expiry takes precedence over the abort.
    always_comb begin
        state_nxt = state;
        if (fall) begin
            case (state)
                IDLE:    if (!data_filt) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && wd_expired) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        ev_good    = 1'b0;
        ev_parity  = 1'b0;
        ev_frame   = 1'b0;
        ev_timeout = 1'b0;
        if (fall) begin
            if (state == IDLE && data_filt)
                ev_frame = 1'b1;
            else if (state == STOP) begin
                if (!data_filt)     ev_frame  = 1'b1;
                else if (parity_acc) ev_parity = 1'b1;
                else                ev_good   = 1'b1;
            end
        end else if (state != IDLE && wd_expired) begin
            ev_timeout = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            shift       <= '0;
            bit_cnt     <= '0;
            parity_acc  <= 1'b0;
            wd_cnt      <= '0;
            rx_byte     <= '0;
            rx_strobe   <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            rx_strobe   <= ev_good;
            parity_err  <= ev_parity;
            frame_err   <= ev_frame;
            timeout_err <= ev_timeout;
            if (ev_good) rx_byte <= shift;
            if (fall || state == IDLE) wd_cnt <= '0;
            else if (!wd_expired)      wd_cnt <= wd_cnt + 16'd1;
            if (fall) begin
                case (state)
                    IDLE: begin
                        bit_cnt    <= '0;
                        parity_acc <= 1'b1;
                    end
                    DATA: begin
                        shift      <= {data_filt, shift[7:1]};
                        parity_acc <= parity_acc ^ data_filt;
                        bit_cnt    <= bit_cnt + 3'd1;
                    end
                    PARITY:  parity_acc <= parity_acc ^ data_filt;
                    default: ;
                endcase
            end
        end
    end

    // E0/F0 only arm flags; any other good byte completes a key event.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            key_code    <= '0;
            key_ext     <= 1'b0;
            key_pressed <= 1'b0;
            key_strobe  <= 1'b0;
            ext         <= 1'b0;
            rel         <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (rx_strobe) begin
                case (rx_byte)
                    8'hE0: ext <= 1'b1;
                    8'hF0: rel <= 1'b1;
                    default: begin
                        key_code    <= rx_byte;
                        key_ext     <= ext;
                        key_pressed <= ~rel;
                        key_strobe  <= 1'b1;
                        ext         <= 1'b0;
                        rel         <= 1'b0;
                    end
                endcase
            end else if (parity_err || frame_err || timeout_err) begin
                ext <= 1'b0;
                rel <= 1'b0;
            end
        end
    end

    assign bus.rx_byte     = rx_byte;
    assign bus.rx_strobe   = rx_strobe;
    assign bus.parity_err  = parity_err;
    assign bus.frame_err   = frame_err;
    assign bus.timeout_err = timeout_err;
    assign bus.key_code    = key_code;
    assign bus.key_ext     = key_ext;
    assign bus.key_pressed = key_pressed;
    assign bus.key_strobe  = key_strobe;
endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - randomized frame bench for ps2_rx against a byte/key event model
module tb_ps2_rx;
    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    ps2_rx_if bus();

    ps2_rx #(.FILTER(4), .TIMEOUT(2500)) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0, n_fail = 0;
    int c_rx = 0, c_perr = 0, c_ferr = 0, c_terr = 0, c_key = 0;

    logic [7:0] m_rx_byte = 8'h00, m_key_code = 8'h00;
    logic       m_key_ext = 1'b0, m_key_pressed = 1'b0, m_ext = 1'b0, m_rel = 1'b0;

    always @(negedge clk_sys) begin
        if (!reset) begin
            c_rx   += int'(bus.rx_strobe);
            c_perr += int'(bus.parity_err);
            c_ferr += int'(bus.frame_err);
            c_terr += int'(bus.timeout_err);
            c_key  += int'(bus.key_strobe);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n, input int hp, input bit glitch);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = bits[i];
            if (glitch) begin
                tick(hp / 2);
                bus.ps2_clk = 1'b0;
                tick(2);
                bus.ps2_clk = 1'b1;
                tick(hp - hp / 2 - 2);
            end else begin
                tick(hp);
            end
            bus.ps2_clk = 1'b0;
            tick(hp);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " rx_byte"},     32'(bus.rx_byte),     32'(m_rx_byte));
        chk({tag, " key_code"},    32'(bus.key_code),    32'(m_key_code));
        chk({tag, " key_ext"},     32'(bus.key_ext),     32'(m_key_ext));
        chk({tag, " key_pressed"}, 32'(bus.key_pressed), 32'(m_key_pressed));
    endtask

    task automatic do_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int hp, input bit glitch);
        int  s_rx, s_perr, s_ferr, s_terr, s_key;
        bit  good, is_key;
        string tag;
        s_rx = c_rx; s_perr = c_perr; s_ferr = c_ferr; s_terr = c_terr; s_key = c_key;
        send_bits({stop, par, b, 1'b0}, 11, hp, glitch);
        tick(20);
        good   = stop && ((^b) ^ par);
        is_key = good && b != 8'hE0 && b != 8'hF0;
        if (good) begin
            m_rx_byte = b;
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_rel = 1'b1;
        end
        if (is_key) begin
            m_key_code = b; m_key_ext = m_ext; m_key_pressed = !m_rel;
        end
        if (!good || is_key) begin
            m_ext = 1'b0; m_rel = 1'b0;
        end
        tag = $sformatf("frame %02h p%0d s%0d", b, par, stop);
        chk({tag, " rx_strobe"},  32'(c_rx - s_rx),     32'(good));
        chk({tag, " parity_err"}, 32'(c_perr - s_perr), 32'(stop && !good));
        chk({tag, " frame_err"},  32'(c_ferr - s_ferr), 32'(!stop));
        chk({tag, " timeout"},    32'(c_terr - s_terr), 32'd0);
        chk({tag, " key_strobe"}, 32'(c_key - s_key),   32'(is_key));
        check_outputs(tag);
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ~(^b);
    endfunction

    initial begin
        int s_terr, s_rx;
        logic [7:0] b;
        logic par, stop;
        int r;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        tick(5);
        check_outputs("reset");
        chk("reset strobes", 32'({bus.rx_strobe, bus.parity_err, bus.frame_err,
                                  bus.timeout_err, bus.key_strobe}), 32'd0);
        reset = 1'b0;
        tick(10);

        do_frame(8'h1C, 1'b0, 1'b1, 1000, 1'b0);
        do_frame(8'hE0, odd_par(8'hE0), 1'b1, 20, 1'b0);
        do_frame(8'hF0, odd_par(8'hF0), 1'b1, 20, 1'b0);
        do_frame(8'h75, odd_par(8'h75), 1'b1, 20, 1'b0);
        do_frame(8'h1C, odd_par(8'h1C), 1'b1, 20, 1'b0);
        do_frame(8'h1C, 1'b1, 1'b1, 20, 1'b0);
        do_frame(8'hF0, odd_par(8'hF0), 1'b1, 20, 1'b0);
        do_frame(8'h33, ~odd_par(8'h33), 1'b1, 20, 1'b0);
        do_frame(8'h1C, odd_par(8'h1C), 1'b1, 20, 1'b0);
        do_frame(8'h1C, odd_par(8'h1C), 1'b0, 20, 1'b0);

        do_frame(8'hE0, odd_par(8'hE0), 1'b1, 20, 1'b0);
        s_terr = c_terr; s_rx = c_rx;
        send_bits({2'b11, 8'h15, 1'b0}, 6, 20, 1'b0);
        tick(2600);
        m_ext = 1'b0; m_rel = 1'b0;
        chk("timeout count", 32'(c_terr - s_terr), 32'd1);
        chk("timeout rx",    32'(c_rx - s_rx),     32'd0);
        do_frame(8'h5A, odd_par(8'h5A), 1'b1, 20, 1'b0);

        do_frame(8'hA5, odd_par(8'hA5), 1'b1, 20, 1'b1);

        send_bits({odd_par(8'h29), 1'b1, 8'h29, 1'b0}, 5, 20, 1'b0);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        m_rx_byte = 8'h00; m_key_code = 8'h00; m_key_ext = 1'b0;
        m_key_pressed = 1'b0; m_ext = 1'b0; m_rel = 1'b0;
        tick(5);
        check_outputs("mid-frame reset");
        do_frame(8'h29, odd_par(8'h29), 1'b1, 20, 1'b0);

        for (int i = 0; i < 14; i++) begin
            b = 8'($urandom);
            r = int'($urandom_range(0, 9));
            if (r == 0) b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            par  = odd_par(b);
            stop = 1'b1;
            r = int'($urandom_range(0, 5));
            if (r == 0) par = ~par;
            else if (r == 1) stop = 1'b0;
            do_frame(b, par, stop, int'($urandom_range(7, 40)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_rx.md
# ps2_rx

Receiver for the PS/2 keyboard/mouse serial link driven by the host-I/O block: samples the open-collector style clock/data pair in the `clk_sys` domain and deserializes 11-bit frames into bytes. It checks start, parity and stop bits, aborts stalled frames, and assembles keyboard scan codes (E0/F0 prefixes) into key events. It sits in the core next to the host-I/O block and is instantiated once per PS/2 channel (keyboard, mouse).

## Interface
- `FILTER`, default 4: consecutive identical synchronized samples required before a filtered line level changes (range 1..15).
- `TIMEOUT`, default 20000: `clk_sys` cycles without a falling clock edge mid-frame before the frame is aborted (16-bit counter).
- `clk_sys` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ps2_clk` in 1: PS/2 clock line, idle high, asynchronous to `clk_sys`.
- `ps2_data` in 1: PS/2 data line, stable at every falling `ps2_clk` edge.
- `rx_byte` out 8: last correctly received byte; holds until the next good byte.
- `rx_strobe` out 1: one-cycle pulse when `rx_byte` updates.
- `parity_err` out 1: one-cycle pulse when a frame has bad odd parity; the byte is discarded.
- `frame_err` out 1: one-cycle pulse on start bit = 1 or stop bit = 0; the byte is discarded.
- `timeout_err` out 1: one-cycle pulse when a partial frame is aborted.
- `key_code` out 8: scan code of the last key event.
- `key_ext` out 1: the last key event was E0-prefixed.
- `key_pressed` out 1: 1 = make, 0 = break (F0-prefixed).
- `key_strobe` out 1: one-cycle pulse when `key_code`, `key_ext` and `key_pressed` update together.

## Operation
- Input conditioning: each line passes a 2-flop synchronizer, then a saturating filter counter. The filtered level flips only after `FILTER` consecutive synchronized samples differ from it. The filtered levels reset to 1.
- Falling edge = filtered clock 1→0, registered as a single-cycle `fall` pulse. Data is taken from the filtered data level in the same cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall`, if data = 0 go to DATA with bit count 0 and parity accumulator 1. If data = 1, pulse `frame_err` and stay in IDLE.
  - DATA: on `fall`, shift data in LSB-first, XOR data into parity, increment count. After the 8th bit go to PARITY.
  - PARITY: on `fall`, XOR the received bit into the accumulator, then go to STOP.
  - STOP: on `fall`, return to IDLE.
    - If stop = 0: pulse `frame_err`.
    - Else if the accumulator ≠ 0 (i.e. the sum of data + parity ones is even): pulse `parity_err`.
    - Else: load `rx_byte` and pulse `rx_strobe`.
  - Only one error pulse per frame; stop error has priority.
- Watchdog: a counter clears on every `fall` and while in IDLE, and increments otherwise. When it reaches `TIMEOUT`, go to IDLE, pulse `timeout_err` and discard the partial byte. The counter saturates; no wrap.
- Scan-code assembler: acts only on `rx_strobe`.
  - 0xE0 sets the ext flag.
  - 0xF0 sets the rel flag.
  - Any other byte loads `key_code`, sets `key_ext` = ext and `key_pressed` = ~rel, pulses `key_strobe`, then clears both flags.
  - `parity_err`, `frame_err` or `timeout_err` also clear both flags.
  - 0xE1, 0xAA and 0xFA get no special handling; they are emitted as codes.
- Simultaneous events: the watchdog expiring in the same cycle as `fall` does not abort; the `fall` wins and the counter clears.
- Reset mid-frame: FSM to IDLE, all partial state and flags cleared. The remainder of an in-flight frame is rejected as a frame error if its next sampled bit is 1; otherwise it is taken as a new start bit.

## Timing
- Reset values:
  - `rx_byte` = 0x00, `key_code` = 0x00.
  - `key_ext` = 0, `key_pressed` = 0.
  - All strobes and error pulses = 0.
  - Filtered lines = 1, FSM = IDLE, watchdog = 0.
- Latency from the `clk_sys` edge that first samples a pin transition to `fall`: 2 (sync) + `FILTER` + 1 cycles.
- `rx_strobe` / error pulse: the cycle after the stop-bit `fall`.
- `key_strobe`: 1 cycle after `rx_strobe`.
- Glitches shorter than `FILTER` cycles are ignored.
- Minimum PS/2 clock half-period supported: `FILTER` + 3 `clk_sys` cycles.
- Back-to-back frames are allowed: the next start-bit `fall` may arrive the cycle after the stop-bit `fall`.

## Test plan
- Frame 0x1C, parity bit 0, stop bit 1, driven by a transmitter with half-period 1000 cycles -> `rx_byte` = 0x1C with one `rx_strobe`; `key_code` = 0x1C, `key_pressed` = 1, `key_ext` = 0.
- Sequence E0, F0, 75 -> a single `key_strobe` with `key_code` = 0x75, `key_ext` = 1, `key_pressed` = 0. A following 0x1C yields `key_ext` = 0, `key_pressed` = 1.
- 0x1C with parity bit 1 -> `parity_err` pulse; no `rx_strobe`; `rx_byte` keeps its previous value. After F0 followed by a bad-parity frame, a good 0x1C yields `key_pressed` = 1.
- 0x1C with stop bit 0 -> `frame_err` pulse only.
- Start bit, then 5 data bits, then the clock held high for `TIMEOUT` cycles -> `timeout_err` exactly once. A following 0x5A frame is received correctly.
- 2-cycle low glitches on `ps2_clk` between valid bits of 0xA5 -> ignored; `rx_byte` = 0xA5. Also, `reset` asserted after the 4th data bit, then a full 0x29 frame -> `rx_byte` = 0x29 with no error pulses.
